// File: rtl/link_pkg.sv
// rtl/link_pkg.sv - shared link types, encoding constants and transmitter states
package link_pkg;

    typedef logic [1:0] multi_rail_bit;

    localparam logic [15:0] ENC_TP = "TP";
    localparam logic [15:0] ENC_FP = "FP";

    localparam multi_rail_bit RAIL_ONE    = 2'b10;
    localparam multi_rail_bit RAIL_ZERO   = 2'b01;
    localparam multi_rail_bit RAIL_SPACER = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_SET,
        ST_SPACER,
        ST_WAIT_CLR
    } state_t;

endpackage

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - two-flop synchronizer for an asynchronous acknowledge
module ack_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/link_tx_arbiter.sv
// rtl/link_tx_arbiter.sv - round-robin requester arbiter serializing words onto a multi-rail link
module link_tx_arbiter
    import link_pkg::*;
#(
    parameter logic [15:0] ENC     = ENC_TP,
    parameter int          NUM_REQ = 4,
    parameter int          DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output multi_rail_bit              tx_data,
    input  logic                       tx_ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int              GW       = $clog2(NUM_REQ);
    localparam int              CW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam bit              IS_FP    = (ENC == ENC_FP);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_W - 1);
    localparam logic [GW-1:0]   LAST_REQ = GW'(NUM_REQ - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    multi_rail_bit       tx_q, tx_d;
    logic                exp_ack_q, exp_ack_d;
    logic                busy_q, busy_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;

    logic                ack_s;
    logic                pick_found;
    logic [GW-1:0]       pick_idx;
    logic [GW-1:0]       cand;
    logic                token_done;
    logic                last_token;
    multi_rail_bit       rail_bit;

    ack_sync u_ack_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (tx_ack),
        .sync_out (ack_s)
    );

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign rail_bit   = shift_q[0] ? RAIL_ONE : RAIL_ZERO;
    assign last_token = (bit_cnt_q == LAST_BIT);
    assign token_done = (!IS_FP && state_q == ST_WAIT_SET && ack_s == exp_ack_q)
                     || (state_q == ST_WAIT_CLR && !ack_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pick_found) state_d = ST_SEND;
            ST_SEND:     state_d = ST_WAIT_SET;
            ST_WAIT_SET: begin
                if (ack_s == exp_ack_q) begin
                    if (IS_FP)           state_d = ST_SPACER;
                    else if (last_token) state_d = ST_IDLE;
                    else                 state_d = ST_SEND;
                end
            end
            ST_SPACER:   state_d = ST_WAIT_CLR;
            ST_WAIT_CLR: if (!ack_s) state_d = last_token ? ST_IDLE : ST_SEND;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        exp_ack_d = exp_ack_q;
        busy_d    = busy_q;
        grant_d   = grant_q;
        last_d    = last_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found && !rst) begin
                    req_ready[pick_idx] = 1'b1;
                end
                if (pick_found) begin
                    shift_d   = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    bit_cnt_d = '0;
                    grant_d   = pick_idx;
                    last_d    = pick_idx;
                    busy_d    = 1'b1;
                end
            end
            ST_SEND: begin
                // Two-phase flips one rail so the link parity alternates per token.
                if (IS_FP) begin
                    tx_d      = rail_bit;
                    exp_ack_d = 1'b1;
                end else begin
                    tx_d      = tx_q ^ rail_bit;
                    exp_ack_d = ^(tx_q ^ rail_bit);
                end
            end
            ST_SPACER: tx_d = RAIL_SPACER;
            default: ;
        endcase
        if (token_done) begin
            if (last_token) begin
                busy_d = 1'b0;
            end else begin
                shift_d   = shift_q >> 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= RAIL_SPACER;
            exp_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= '0;
            last_q    <= LAST_REQ;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            exp_ack_q <= exp_ack_d;
            busy_q    <= busy_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
        end
    end

    assign tx_data  = tx_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_link_tx_arbiter.sv
// tb/tb_link_tx_arbiter.sv - self-checking bench for link_tx_arbiter in TP and FP signalling
module tb_link_tx_arbiter;
    import link_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NR-1:0]    t_valid = '0, t_ready;
    logic [NR*DW-1:0] t_data  = '0;
    multi_rail_bit    t_tx;
    logic             t_ack = 1'b0, t_busy;
    logic [1:0]       t_gid;

    logic [NR-1:0]    f_valid = '0, f_ready;
    logic [NR*DW-1:0] f_data  = '0;
    multi_rail_bit    f_tx;
    logic             f_ack = 1'b0, f_busy;
    logic [1:0]       f_gid;

    link_tx_arbiter #(.ENC(ENC_TP), .NUM_REQ(NR), .DATA_W(DW)) u_tp (
        .clk(clk), .rst(rst), .req_valid(t_valid), .req_data(t_data), .req_ready(t_ready),
        .tx_data(t_tx), .tx_ack(t_ack), .busy(t_busy), .grant_id(t_gid));

    link_tx_arbiter #(.ENC(ENC_FP), .NUM_REQ(NR), .DATA_W(DW)) u_fp (
        .clk(clk), .rst(rst), .req_valid(f_valid), .req_data(f_data), .req_ready(f_ready),
        .tx_data(f_tx), .tx_ack(f_ack), .busy(f_busy), .grant_id(f_gid));

    int n_checks = 0;
    int n_fail   = 0;

    int            t_dly = 1, f_dly = 1;
    logic [63:0]   t_hist = '0, f_hist = '0;
    multi_rail_bit t_prev = 2'b00, f_prev = 2'b00;
    logic [NR-1:0] t_acc_mask = '0, f_acc_mask = '0;
    int            mdl_last = NR - 1;
    int            t_exp_rail[$], t_obs_rail[$];
    int            exp_gid[$], obs_gid[$];
    multi_rail_bit f_obs[$];
    int            rdy_cycles = 0, rdy_bad = 0;
    bit            f_saw11 = 1'b0;

    int            t_left[NR] = '{0, 0, 0, 0};
    int            t_total = 0;
    logic [NR-1:0] t_en = '1;

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic int idx_of(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Link cells: each ack is the rail parity seen some cycles ago.
    always @(negedge clk) begin
        int            e;
        multi_rail_bit d;
        t_hist = {t_hist[62:0], ^t_tx};
        f_hist = {f_hist[62:0], ^f_tx};
        if (rst) begin
            t_hist = '0;
            f_hist = '0;
        end
        t_ack = t_hist[t_dly];
        f_ack = f_hist[f_dly];
        if (rst) begin
            t_prev = t_tx;
            f_prev = f_tx;
            mdl_last = NR - 1;
            t_acc_mask = '0;
            f_acc_mask = '0;
            t_exp_rail.delete();
            t_obs_rail.delete();
            exp_gid.delete();
            obs_gid.delete();
        end else begin
            t_acc_mask = t_valid & t_ready;
            f_acc_mask = f_valid & f_ready;
            if (t_ready != '0) begin
                rdy_cycles++;
                if (!$onehot(t_ready)) rdy_bad++;
            end
            if (t_acc_mask != '0) begin
                e = rr_pick(t_valid, mdl_last);
                exp_gid.push_back(e);
                obs_gid.push_back(idx_of(t_acc_mask));
                if (e >= 0) begin
                    mdl_last = e;
                    for (int b = 0; b < DW; b++) t_exp_rail.push_back(int'(t_data[e*DW + b]));
                end
            end
            if (t_tx != t_prev) begin
                d = t_tx ^ t_prev;
                t_obs_rail.push_back(d == 2'b10 ? 1 : (d == 2'b01 ? 0 : 2));
            end
            t_prev = t_tx;
            if (f_tx != f_prev) f_obs.push_back(f_tx);
            if (f_tx == 2'b11) f_saw11 = 1'b1;
            f_prev = f_tx;
        end
    end

    // Requesters present a fresh word after each accept while they have words left.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin
                if (t_acc_mask[i]) begin
                    if (t_left[i] > 0) t_left[i]--;
                    if (t_total > 0) t_total--;
                    t_data[i*DW +: DW] = DW'($urandom);
                end
                t_valid[i] = t_en[i] && (t_left[i] > 0) && (t_total > 0);
            end
        end
    end

    task automatic clear_sb();
        t_exp_rail.delete();
        t_obs_rail.delete();
        exp_gid.delete();
        obs_gid.delete();
        f_obs.delete();
        rdy_cycles = 0;
        rdy_bad = 0;
        f_saw11 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        t_left = '{0, 0, 0, 0};
        t_total = 0;
        t_en = '1;
        t_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_tp_done(input int budget, output bit ok);
        int c = 0;
        ok = 1'b0;
        while (!ok && c < budget) begin
            @(negedge clk);
            #1;
            c++;
            if (t_total == 0 && !t_busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        t_valid = '1;
        f_valid = '1;
        #12;
        n_checks++; if (t_tx !== 2'b00) begin n_fail++; $display("FAIL reset_tx got %b expected 00", t_tx); end
        n_checks++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", t_busy); end
        n_checks++; if (t_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got %b expected 0000", t_ready); end
        n_checks++; if (t_gid !== 2'd0) begin n_fail++; $display("FAIL reset_gid got %0d expected 0", t_gid); end
        n_checks++; if (f_tx !== 2'b00 || f_ready !== 4'b0000) begin
            n_fail++; $display("FAIL reset_fp got tx=%b ready=%b expected 00/0000", f_tx, f_ready);
        end
        t_valid = '0;
        f_valid = '0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_tp_single();
        bit         ok;
        logic [7:0] w = 8'hA5;
        @(negedge clk); #1;
        clear_sb();
        t_dly = 1;
        t_data[7:0] = w;
        t_left = '{1, 0, 0, 0};
        t_total = 1;
        wait_tp_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tp_single_timeout got busy=%b expected 0", t_busy); end
        n_checks++; if (obs_gid.size() != 1 || obs_gid[0] !== 0) begin
            n_fail++; $display("FAIL tp_single_grant got %0d grants expected one grant of 0", obs_gid.size());
        end
        n_checks++; if (t_obs_rail.size() != 8) begin
            n_fail++; $display("FAIL tp_single_tokens got %0d expected 8", t_obs_rail.size());
        end
        for (int k = 0; k < 8 && k < t_obs_rail.size(); k++) begin
            n_checks++; if (t_obs_rail[k] !== int'(w[k])) begin
                n_fail++; $display("FAIL tp_single_rail[%0d] got %0d expected %0d", k, t_obs_rail[k], w[k]);
            end
        end
        n_checks++; if (t_tx !== 2'b00) begin n_fail++; $display("FAIL tp_single_end_tx got %b expected 00", t_tx); end
        n_checks++; if (t_gid !== 2'd0) begin n_fail++; $display("FAIL tp_single_gid got %0d expected 0", t_gid); end
    endtask

    task automatic test_fp_single();
        bit            ok = 1'b0;
        int            c = 0;
        logic [7:0]    w = 8'h03;
        multi_rail_bit e;
        @(negedge clk); #1;
        clear_sb();
        f_dly = $urandom_range(1, 4);
        @(posedge clk); #2;
        f_data[7:0] = w;
        f_valid = 4'b0001;
        while (!ok && c < 20) begin @(negedge clk); #1; c++; if (f_acc_mask[0]) ok = 1'b1; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fp_accept got ready=%b expected 0001", f_ready); end
        @(posedge clk); #2;
        f_valid = '0;
        ok = 1'b0; c = 0;
        while (!ok && c < 600) begin @(negedge clk); #1; c++; if (!f_busy) ok = 1'b1; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL fp_timeout got busy=%b expected 0", f_busy); end
        n_checks++; if (f_obs.size() != 16) begin
            n_fail++; $display("FAIL fp_changes got %0d expected 16", f_obs.size());
        end
        for (int k = 0; k < 16 && k < f_obs.size(); k++) begin
            e = (k % 2 == 1) ? 2'b00 : (w[k/2] ? 2'b10 : 2'b01);
            n_checks++; if (f_obs[k] !== e) begin
                n_fail++; $display("FAIL fp_token[%0d] got %b expected %b", k, f_obs[k], e);
            end
        end
        n_checks++; if (f_saw11 !== 1'b0) begin n_fail++; $display("FAIL fp_rails_11 got 1 expected 0"); end
        n_checks++; if (f_tx !== 2'b00) begin n_fail++; $display("FAIL fp_idle_tx got %b expected 00", f_tx); end
        n_checks++; if (f_gid !== 2'd0) begin n_fail++; $display("FAIL fp_gid got %0d expected 0", f_gid); end
    endtask

    task automatic test_reset_mid_word();
        bit ok = 1'b0;
        int c = 0;
        do_reset();
        clear_sb();
        t_dly = 10;
        t_en = 4'b0001;
        t_left = '{1, 0, 1, 0};
        t_total = 5;
        while (!ok && c < 500) begin @(negedge clk); #1; c++; if (t_obs_rail.size() >= 4) ok = 1'b1; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midword_reach got %0d tokens expected 4", t_obs_rail.size()); end
        #1;
        t_valid = 4'b0101;
        rst = 1'b1;
        #1;
        n_checks++; if (t_tx !== 2'b00) begin n_fail++; $display("FAIL midword_tx got %b expected 00", t_tx); end
        n_checks++; if (t_busy !== 1'b0) begin n_fail++; $display("FAIL midword_busy got %b expected 0", t_busy); end
        n_checks++; if (t_ready !== 4'b0000) begin n_fail++; $display("FAIL midword_ready got %b expected 0000", t_ready); end
        @(negedge clk);
        t_valid = '0;
        #3 rst = 1'b0;
        t_left = '{1, 0, 1, 0};
        t_en = '1;
        t_total = 2;
        wait_tp_done(1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midword_timeout got busy=%b expected 0", t_busy); end
        n_checks++; if (obs_gid.size() != 2 || obs_gid[0] !== 0) begin
            n_fail++; $display("FAIL midword_first_grant got size=%0d expected first grant 0", obs_gid.size());
        end
        n_checks++; if (obs_gid.size() == 2 && obs_gid[1] !== exp_gid[1]) begin
            n_fail++; $display("FAIL midword_second_grant got %0d expected %0d", obs_gid[1], exp_gid[1]);
        end
        n_checks++; if (t_obs_rail != t_exp_rail) begin
            n_fail++; $display("FAIL midword_stream got %0d tokens expected %0d matching", t_obs_rail.size(), t_exp_rail.size());
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        clear_sb();
        t_dly = $urandom_range(1, 3);
        for (int i = 0; i < NR; i++) t_data[i*DW +: DW] = DW'($urandom);
        t_left = '{9, 9, 9, 9};
        t_total = 5;
        wait_tp_done(2000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout got busy=%b expected 0", t_busy); end
        n_checks++; if (obs_gid.size() != 5) begin n_fail++; $display("FAIL rr_count got %0d expected 5", obs_gid.size()); end
        for (int k = 0; k < obs_gid.size() && k < 5; k++) begin
            n_checks++; if (obs_gid[k] !== exp_gid[k] || obs_gid[k] !== (k % NR)) begin
                n_fail++; $display("FAIL rr_grant[%0d] got %0d expected %0d", k, obs_gid[k], k % NR);
            end
        end
        n_checks++; if (rdy_cycles != 5 || rdy_bad != 0) begin
            n_fail++; $display("FAIL rr_ready_pulses got %0d (bad %0d) expected 5 (bad 0)", rdy_cycles, rdy_bad);
        end
        n_checks++; if (t_obs_rail != t_exp_rail) begin
            n_fail++; $display("FAIL rr_stream got %0d tokens expected %0d matching", t_obs_rail.size(), t_exp_rail.size());
        end
        n_checks++; if (t_gid !== 2'd0) begin n_fail++; $display("FAIL rr_gid got %0d expected 0", t_gid); end
    endtask

    task automatic test_slow_ack();
        bit ok;
        int r = $urandom_range(0, NR - 1);
        @(negedge clk); #1;
        clear_sb();
        t_dly = 20;
        t_data[r*DW +: DW] = DW'($urandom);
        t_left = '{0, 0, 0, 0};
        t_left[r] = 1;
        t_total = 1;
        wait_tp_done(1500, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL slow_timeout got busy=%b expected 0", t_busy); end
        n_checks++; if (t_obs_rail.size() != DW) begin
            n_fail++; $display("FAIL slow_changes got %0d expected %0d", t_obs_rail.size(), DW);
        end
        n_checks++; if (t_obs_rail != t_exp_rail) begin
            n_fail++; $display("FAIL slow_stream got %0d tokens expected %0d matching", t_obs_rail.size(), t_exp_rail.size());
        end
        n_checks++; if (obs_gid.size() != 1 || obs_gid[0] !== r) begin
            n_fail++; $display("FAIL slow_grant got %0d grants expected one grant of %0d", obs_gid.size(), r);
        end
    endtask

    task automatic test_late_drop();
        bit ok = 1'b0;
        int c = 0;
        do_reset();
        clear_sb();
        t_dly = 2;
        t_en = 4'b0010;
        t_left = '{0, 1, 1, 1};
        t_total = 2;
        while (!ok && c < 50) begin @(negedge clk); #1; c++; if (obs_gid.size() >= 1) ok = 1'b1; end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_first_accept got none expected grant 1"); end
        t_en[2] = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        t_en[2] = 1'b0;
        t_en[3] = 1'b1;
        wait_tp_done(1000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_timeout got busy=%b expected 0", t_busy); end
        n_checks++; if (obs_gid.size() != 2 || obs_gid[0] !== 1 || obs_gid[1] !== exp_gid[1]) begin
            n_fail++; $display("FAIL drop_grants got size=%0d expected grants 1 then 3", obs_gid.size());
        end
        for (int k = 0; k < obs_gid.size(); k++) begin
            n_checks++; if (obs_gid[k] === 2) begin
                n_fail++; $display("FAIL drop_req2_granted got grant 2 at %0d expected never", k);
            end
        end
        n_checks++; if (t_gid !== 2'd3) begin n_fail++; $display("FAIL drop_gid got %0d expected 3", t_gid); end
        n_checks++; if (t_obs_rail != t_exp_rail) begin
            n_fail++; $display("FAIL drop_stream got %0d tokens expected %0d matching", t_obs_rail.size(), t_exp_rail.size());
        end
    endtask

    initial begin
        test_reset();
        test_tp_single();
        test_fp_single();
        test_reset_mid_word();
        test_round_robin();
        test_slow_ack();
        test_late_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/link_tx_arbiter.md
# link_tx_arbiter

Clocked front end that shares one asynchronous multi-rail link among NUM_REQ synchronous requesters. A round-robin arbiter grants one requester, captures its DATA_W-bit word and serializes it LSB first as one multi-rail token per bit into a chain of MEM_CELL latches. A two-flop synchronizer brings the chain's acknowledge into the clock domain. The block sits at every sync-to-async boundary of the design and supports two-phase (TP) and four-phase (FP) signalling.

## Interface
- ENC, "TP", link signalling: "TP" two-phase transition, "FP" four-phase return-to-spacer.
- NUM_REQ, 4, number of requesters, 2..16.
- DATA_W, 8, word width in bits, 1..32.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester word valid.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i at [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept; transfer on valid&&ready.
- tx_data  out  multi_rail_bit (2)  link rails; [1]=logic-1 rail, [0]=logic-0 rail.
- tx_ack  in  1  asynchronous ack from first MEM_CELL (XOR of its rails).
- busy  out  1  high from accept until last token completes.
- grant_id  out  $clog2(NUM_REQ)  index of the requester being served; holds last value when idle.

## Operation
- States: IDLE, SEND, WAIT_SET, SPACER, WAIT_CLR. SPACER and WAIT_CLR are used only when ENC=="FP".
- IDLE: search from (last_grant+1) mod NUM_REQ upward with wrap, and pick the first requester with valid set. Assert req_ready for that index only, combinationally, in the same cycle. On transfer: capture the word into the shift register, set bit_cnt=0, update grant_id and last_grant, set busy=1, and go to SEND.
- SEND, TP: toggle tx_data[b], where b = shift[0]. Set exp_ack = ^(new tx_data). Go to WAIT_SET.
- SEND, FP: set tx_data = b ? 2'b10 : 2'b01. Set exp_ack=1. Go to WAIT_SET.
- WAIT_SET: stay until ack_s == exp_ack.
  - TP: then treat the token as complete.
  - FP: then go to SPACER.
- SPACER (FP only): set tx_data=2'b00 and go to WAIT_CLR.
- WAIT_CLR (FP only): stay until ack_s == 0, then treat the token as complete.
- Token complete: if bit_cnt==DATA_W-1, clear busy and go to IDLE. Otherwise shift right, increment bit_cnt and go to SEND.
- Only one rail changes per TP token. tx_data never equals 2'b11.
- In IDLE, tx_data holds its rails: TP keeps the current parity, FP holds 2'b00.
- req_ready is 0 in every state except IDLE. A requester that drops valid before it is granted loses nothing.
- last_grant resets to NUM_REQ-1, so requester 0 has first priority after reset.

## Timing
- Reset (asynchronous, any state): tx_data=2'b00, req_ready=0, busy=0, grant_id=0, last_grant=NUM_REQ-1, both sync flops=0, state=IDLE.
  - The downstream MEM_CELL chain shares rst, so link parity realigns.
  - A word in flight is dropped; nothing is retransmitted.
- Accept cycle N; first token rail change is registered at edge N+1.
- ack_s is tx_ack after two flops. A tx_ack edge becomes visible in WAIT_* two or three cycles later.
- Per-token minimum cost:
  - TP: 1 + 2 cycles plus link delay.
  - FP: 2×(1 + 2) cycles plus link delay.
- Word cost: DATA_W × per-token cost, plus one IDLE cycle before the next accept. Back-to-back words therefore have one idle cycle between them.
- An ack change outside WAIT_* is ignored. A stuck ack holds WAIT_* indefinitely; there is no timeout.
- Simultaneous valids in IDLE resolve by round-robin order only.

## Structure
- link_pkg (shared) holds:
  - typedef multi_rail_bit (logic [1:0]);
  - enc constants ENC_TP/ENC_FP;
  - the state enum.
- Sub-module ack_sync: 2-flop synchronizer with asynchronous reset to 0, reused wherever an async ack enters a clock domain.
- Arbiter search, FSM and shift register live in link_tx_arbiter.

## Test plan
- Reset mid-word: assert rst while in WAIT_SET of bit 3 → immediately tx_data=00, busy=0, req_ready=0. After release, requester 0 is granted first.
- TP single word: DATA_W=8, req0 sends 0xA5, and the bench model flips tx_ack on each token. Expected:
  - rail toggles in order 1,0,1,0,0,1,0,1 (LSB first);
  - 8 tokens, then busy falls;
  - tx_data ends at 2'b00, since four toggles on each rail return both to 0.
- FP single word: send 0x03 → tokens 10,spacer,10,spacer,01,spacer…, for 8 valid/spacer pairs. tx_data is 00 while idle and 11 never occurs.
- Round robin: all 4 valids held high → grant_id sequence 0,1,2,3,0, with exactly one req_ready pulse per word.
- Slow ack: the bench delays each tx_ack by 20 cycles → the FSM stays in WAIT_SET with no extra rail change, and the data is intact.
- Late valid drop: req2 is valid for 5 cycles during req1's word and then drops → req2 is never granted and the next grant goes to the next valid requester.
